instr_fetch: RTL and testbench
==============================

# instr_fetch

Fetch stage directly downstream of the program counter. Reads the PC value, issues a one-cycle read to the synchronous instruction ROM and latches the returned word into a one-entry instruction register. It presents that word to the decoder with a valid/ready handshake and pulses `nxinst` back to the PC stage. It also discards in-flight work when the execute stage redirects the PC.

## Interface
- `ADDR_W`, 8: PC / ROM address width
- `INSTR_W`, 32: instruction word width
- `cout`  in  1: clock; all state updates on rising edge
- `rst`  in  1: reset, asynchronous, active-high
- `pc`  in  ADDR_W: current PC from the PC stage
- `redirect`  in  1: branch/jump taken this cycle; driven in the same cycle as the PC stage's `override_en`
- `nxinst`  out  1: one-cycle pulse; PC stage advances by 1
- `imem_en`  out  1: ROM read enable
- `imem_addr`  out  ADDR_W: ROM read address
- `imem_rdata`  in  INSTR_W: ROM data, valid the cycle after `imem_en`
- `ir`  out  INSTR_W: latched instruction
- `ir_pc`  out  ADDR_W: address `ir` was fetched from
- `ir_valid`  out  1: `ir` holds an unconsumed instruction
- `ir_ready`  in  1: decoder accepts `ir` when `ir_valid && ir_ready`

## Operation
- FSM states: IDLE, ISSUE, MEMWAIT, SETTLE, HOLD.
- IDLE: reset state. Goes unconditionally to ISSUE.
- ISSUE:
  - `imem_en=1`, `imem_addr=pc`; `fetch_pc` captures `pc`.
  - Next state MEMWAIT.
- MEMWAIT:
  - `nxinst=1` (combinational from state).
  - At the edge: `ir<=imem_rdata`, `ir_pc<=fetch_pc`, `ir_valid<=1`.
  - Next state SETTLE.
- SETTLE: the PC stage's output changes at the end of this cycle.
  - Next state ISSUE if `ir_valid==0` or `ir_ready==1`; otherwise HOLD.
- HOLD: waits for the decoder. Next state ISSUE when `ir_ready==1`.
- Handshake: `ir_valid && ir_ready` at an edge clears `ir_valid`. `ir` and `ir_pc` hold their last values until the next MEMWAIT load.
- `ir`, `ir_pc` and `ir_valid` are stable while `ir_valid=1` and not accepted.
- `redirect=1` in any state:
  - Next state is SETTLE.
  - `nxinst` is forced to 0.
  - A MEMWAIT load is suppressed; `imem_rdata` is dropped.
  - `ir_valid<=0`.
  - An `ir_valid && ir_ready` handshake in the same cycle still counts as accepted; the branch instruction itself is consumed.
- `redirect` overrides all other transitions. Back-to-back redirects keep the FSM in SETTLE.
- IDLE ignores `redirect`.
- Address arithmetic is done by the PC stage only. `pc` wraps 255→0 there, and the fetch stage passes it through unmodified.

## Timing
- Reset values (asynchronous assert): state IDLE, `ir=0`, `ir_pc=0`, `fetch_pc=0`, `ir_valid=0`. Consequently `nxinst=0` and `imem_en=0`.
- Reset asserted mid-fetch aborts immediately. No `nxinst` is emitted and there is no residual valid.
- First ISSUE is the 2nd cycle after reset deassert.
- Latency: ISSUE at cycle n → `ir_valid=1` from cycle n+2.
- PC settling:
  - `nxinst` in cycle n+1 (MEMWAIT) updates the PC stage's internal next-PC at that edge.
  - `pc` shows the new value from cycle n+3, the earliest next ISSUE.
- Peak throughput: 1 instruction / 3 cycles with `ir_ready` held high.
- Redirect in cycle r:
  - Target is latched by the PC stage at edge r and appears on `pc` at cycle r+2.
  - Fetch ISSUEs at r+2 (r→SETTLE at r+1→ISSUE at r+2).
  - First post-redirect `ir_valid` at r+4.
- `imem_en` is never asserted in two consecutive cycles.

## Structure
- Shared package `cpu_pkg`:
  - `fetch_state_t` enum (IDLE, ISSUE, MEMWAIT, SETTLE, HOLD).
  - `ADDR_W` / `INSTR_W` defaults, reused by the PC stage and the decoder.
- Single module. FSM and instruction register are inline; no sub-module, since one state register plus three data registers do not justify a split.

## Test plan
- Reset, then `pc` driven by a PC-stage model, ROM[k]=32'hA000_0000+k, `ir_ready=1`:
  - `ir`=A000_0000, A000_0001, A000_0002 with `ir_pc`=0, 1, 2.
  - `ir_valid` rises every 3rd cycle.
  - Exactly one `nxinst` per fetch.
- `ir_ready=0` for 10 cycles after first valid:
  - FSM in HOLD; `ir`/`ir_pc` stable.
  - No `imem_en`, no extra `nxinst`.
  - Release → next ISSUE the following cycle.
- `redirect` with target 8'h40 asserted during MEMWAIT:
  - `nxinst` stays 0; old data dropped; `ir_valid` 0.
  - Next ISSUE has `imem_addr`=8'h40, 2 cycles after redirect.
- `redirect` coincident with `ir_valid && ir_ready`:
  - Instruction counted accepted once; `ir_valid` 0 next cycle.
  - Refetch from target.
- PC wrap: start at 8'hFE:
  - Fetches at FE, FF, 00; `ir_pc` follows.
  - No X on `imem_addr`.
- Async `rst` pulse mid-MEMWAIT (not on an edge):
  - Outputs go to reset values immediately.
  - No `nxinst`; fetch restarts at the 2nd cycle after deassert.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths and fetch-stage state encoding
package cpu_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        MEMWAIT = 3'd2,
        SETTLE  = 3'd3,
        HOLD    = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: ROM read, one-entry instruction register, redirect flush
module instr_fetch #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               cout,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               redirect,
    output logic               nxinst,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready
);

    cpu_pkg::fetch_state_t state;
    logic [ADDR_W-1:0]     fetch_pc;

    // The PC stage owns all address arithmetic; the ROM sees pc untouched.
    assign imem_en   = (state == cpu_pkg::ISSUE);
    assign imem_addr = pc;
    assign nxinst    = (state == cpu_pkg::MEMWAIT) && !redirect;

    always_ff @(posedge cout or posedge rst) begin
        if (rst) begin
            state    <= cpu_pkg::IDLE;
            fetch_pc <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else begin
            if (ir_valid && ir_ready) begin
                ir_valid <= 1'b0;
            end

            case (state)
                cpu_pkg::IDLE: begin
                    state <= cpu_pkg::ISSUE;
                end
                cpu_pkg::ISSUE: begin
                    fetch_pc <= pc;
                    state    <= cpu_pkg::MEMWAIT;
                end
                cpu_pkg::MEMWAIT: begin
                    if (!redirect) begin
                        ir       <= imem_rdata;
                        ir_pc    <= fetch_pc;
                        ir_valid <= 1'b1;
                    end
                    state <= cpu_pkg::SETTLE;
                end
                cpu_pkg::SETTLE: begin
                    if (!ir_valid || ir_ready) begin
                        state <= cpu_pkg::ISSUE;
                    end else begin
                        state <= cpu_pkg::HOLD;
                    end
                end
                cpu_pkg::HOLD: begin
                    if (ir_ready) begin
                        state <= cpu_pkg::ISSUE;
                    end
                end
                default: begin
                    state <= cpu_pkg::IDLE;
                end
            endcase

            // A redirect flushes everything in flight and gives the PC stage
            // one SETTLE cycle to present the target; IDLE is exempt.
            if (redirect && (state != cpu_pkg::IDLE)) begin
                state    <= cpu_pkg::SETTLE;
                ir_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [7:0]  pc;
    logic        redirect;
    logic        nxinst;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;

    logic [7:0]  next_pc;
    logic [7:0]  pc_init;
    logic [7:0]  redir_target;
    logic        prev_imem_en;

    int checks;
    int passed;
    int accepts;
    int nx_count;
    int en_b2b;

    instr_fetch #(.ADDR_W(8), .INSTR_W(32)) dut (
        .cout       (clk),
        .rst        (rst),
        .pc         (pc),
        .redirect   (redirect),
        .nxinst     (nxinst),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC stage: next-PC register updated by nxinst/redirect, pc trails it by one edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            next_pc <= pc_init;
            pc      <= pc_init;
        end else begin
            if (redirect)
                next_pc <= redir_target;
            else if (nxinst)
                next_pc <= next_pc + 8'd1;
            pc <= next_pc;
        end
    end

    // ROM[k] = A000_0000 + k, one-cycle synchronous read
    always @(posedge clk) begin
        if (imem_en)
            imem_rdata <= 32'hA000_0000 + {24'd0, imem_addr};
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_imem_en <= 1'b0;
        end else begin
            if (nxinst)
                nx_count <= nx_count + 1;
            if (imem_en && prev_imem_en)
                en_b2b <= en_b2b + 1;
            prev_imem_en <= imem_en;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        if (ir_valid && ir_ready)
            accepts++;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered while observing ISSUE; leaves while observing SETTLE.
    task automatic do_fetch(input logic [7:0] a);
        check("issue_en", {31'd0, imem_en}, 32'd1);
        check("issue_addr", {24'd0, imem_addr}, {24'd0, a});
        check("issue_nx", {31'd0, nxinst}, 32'd0);
        check("issue_vld", {31'd0, ir_valid}, 32'd0);
        step();
        check("mw_nx", {31'd0, nxinst}, 32'd1);
        check("mw_en", {31'd0, imem_en}, 32'd0);
        check("mw_vld", {31'd0, ir_valid}, 32'd0);
        step();
        check("st_vld", {31'd0, ir_valid}, 32'd1);
        check("st_ir", ir, 32'hA000_0000 + {24'd0, a});
        check("st_irpc", {24'd0, ir_pc}, {24'd0, a});
        check("st_nx", {31'd0, nxinst}, 32'd0);
    endtask

    int hold_en;
    int hold_nx;
    int hold_bad;

    initial begin
        checks = 0; passed = 0; accepts = 0; nx_count = 0; en_b2b = 0;
        redirect = 1'b0; redir_target = 8'h00; ir_ready = 1'b1;
        pc_init = 8'h00; imem_rdata = 32'd0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_ir", ir, 32'd0);
        check("rst_irpc", {24'd0, ir_pc}, 32'd0);
        check("rst_vld", {31'd0, ir_valid}, 32'd0);
        check("rst_nx", {31'd0, nxinst}, 32'd0);
        check("rst_en", {31'd0, imem_en}, 32'd0);
        rst = 1'b0;
        #1 check("idle_en", {31'd0, imem_en}, 32'd0);
        step();

        do_fetch(8'h00);
        step();
        do_fetch(8'h01);
        step();
        do_fetch(8'h02);

        // decoder stalls for 10 cycles
        ir_ready = 1'b0;
        hold_en = 0; hold_nx = 0; hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (imem_en) hold_en++;
            if (nxinst) hold_nx++;
            if (ir !== 32'hA000_0002 || ir_pc !== 8'h02 || ir_valid !== 1'b1) hold_bad++;
        end
        check("hold_en", hold_en, 0);
        check("hold_nx", hold_nx, 0);
        check("hold_stable", hold_bad, 0);
        ir_ready = 1'b1;
        step();

        // redirect to 0x40 during MEMWAIT of fetch 3
        check("rel_en", {31'd0, imem_en}, 32'd1);
        check("rel_addr", {24'd0, imem_addr}, 32'h03);
        check("rel_vld", {31'd0, ir_valid}, 32'd0);
        step();
        check("pre_redir_nx", {31'd0, nxinst}, 32'd1);
        redirect = 1'b1; redir_target = 8'h40;
        #1 check("redir_nx", {31'd0, nxinst}, 32'd0);
        step();
        redirect = 1'b0;
        check("redir_vld", {31'd0, ir_valid}, 32'd0);
        check("redir_drop", {24'd0, ir_pc}, 32'h02);
        check("redir_en", {31'd0, imem_en}, 32'd0);
        step();
        do_fetch(8'h40);

        // redirect to 0x80 coincident with acceptance of 0x40
        redirect = 1'b1; redir_target = 8'h80;
        step();
        redirect = 1'b0;
        check("acc_cnt", accepts, 4);
        check("acc_vld", {31'd0, ir_valid}, 32'd0);
        check("acc_en", {31'd0, imem_en}, 32'd0);
        step();
        do_fetch(8'h80);
        step();
        check("seq_addr", {24'd0, imem_addr}, 32'h81);
        step();

        // asynchronous reset in the middle of MEMWAIT, then wrap test from FE
        #2 pc_init = 8'hFE; rst = 1'b1;
        #1 check("arst_nx", {31'd0, nxinst}, 32'd0);
        check("arst_vld", {31'd0, ir_valid}, 32'd0);
        check("arst_ir", ir, 32'd0);
        check("arst_irpc", {24'd0, ir_pc}, 32'd0);
        check("arst_en", {31'd0, imem_en}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("arst_idle", {31'd0, imem_en}, 32'd0);
        step();
        do_fetch(8'hFE);
        step();
        do_fetch(8'hFF);
        step();
        do_fetch(8'h00);
        step();

        check("nx_total", nx_count, 8);
        check("acc_total", accepts, 8);
        check("en_b2b", en_b2b, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
